// File: rtl/sha3_squeeze.sv
// rtl/sha3_squeeze.sv - Keccak sponge squeeze stage: streams the first OUT_LANES rate lanes
// Captures one permuted 1600-bit state and emits lanes 0..OUT_LANES-1, one 64-bit lane per beat.
module sha3_squeeze #(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1599:0] state_in,
    input  logic          state_valid,
    output logic          state_ready,
    output logic [63:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          busy
);

    generate
        if (RATE_LANES < 1 || RATE_LANES > 25 || OUT_LANES < 1 || OUT_LANES > RATE_LANES) begin : g_bad_params
            $error("sha3_squeeze: illegal RATE_LANES/OUT_LANES combination");
        end
    endgenerate

    localparam int CW = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(OUT_LANES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_valid;
    logic                     r_last;
    logic [63:0]              r_dout;
    logic [CW-1:0]            r_cnt;
    logic [64*OUT_LANES-1:0]  r_pend;

    logic                     w_capture;
    logic                     w_beat;
    logic [CW-1:0]            w_cnt_inc;
    logic [1663:0]            w_src;
    logic                     w_unused_bits;

    // Zero-padded so the pending-lane slice stays in range even for OUT_LANES=25.
    assign w_src         = {64'b0, state_in};
    assign w_unused_bits = ^w_src;

    always_comb begin
        w_next    = r_state;
        w_capture = (r_state == IDLE) && state_valid && r_ready;
        w_beat    = r_valid && dout_ready;
        w_cnt_inc = r_cnt + CW'(1);
        case (r_state)
            IDLE: if (w_capture) w_next = SEND;
            SEND: if (w_beat && r_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_dout  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == IDLE);
            r_busy  <= (w_next == SEND);
            r_valid <= (w_next == SEND);
            if (w_capture) begin
                r_cnt  <= '0;
                r_dout <= state_in[63:0];
                r_last <= (OUT_LANES == 1);
            end else if (w_beat) begin
                if (r_last) begin
                    r_cnt  <= '0;
                    r_dout <= '0;
                    r_last <= 1'b0;
                end else begin
                    r_cnt  <= w_cnt_inc;
                    r_dout <= r_pend[63:0];
                    r_last <= (w_cnt_inc == LAST_IDX);
                end
            end
        end
    end

    // Lanes 1..OUT_LANES-1 wait here and shift down one lane per accepted beat.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_pend <= w_src[64 +: 64*OUT_LANES];
        end else if (w_beat) begin
            r_pend <= r_pend >> 64;
        end
    end

    assign state_ready = r_ready;
    assign busy        = r_busy;
    assign dout_valid  = r_valid;
    assign dout_last   = r_last;
    assign dout        = r_dout;

endmodule
